// File: rtl/field_accumulator_pkg.sv
// Shared types and field arithmetic parameters for the field accumulator.
// The F_* defines are the single source for field width, prime and adder latency.
`ifndef F_NBITS
`define F_NBITS 8
`endif
`ifndef F_PRIME
`define F_PRIME 251
`endif
`ifndef F_ADD_CYCLES
`define F_ADD_CYCLES 3
`endif

package field_accumulator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_IN,
        ADD,
        DONE
    } state_e;

endpackage

// File: rtl/field_adder.sv
// Pipelined modular adder: c = (a + b) mod p, ready_pulse F_ADD_CYCLES after en.
// Operands must already be reduced below p.
module field_adder (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic [`F_NBITS-1:0] a,
    input  logic [`F_NBITS-1:0] b,
    output logic [`F_NBITS-1:0] c,
    output logic                ready_pulse
);

    localparam int W = `F_NBITS;
    localparam int N = `F_ADD_CYCLES;
    localparam logic [W:0] P_EXT = (W+1)'(`F_PRIME);

    logic [W:0]   raw;
    logic [W:0]   raw_sub;
    logic [W-1:0] red;
    logic [N-1:0] vld;
    logic [W-1:0] dat [N];

    assign raw     = {1'b0, a} + {1'b0, b};
    assign raw_sub = raw - P_EXT;
    assign red     = (raw >= P_EXT) ? raw_sub[W-1:0] : raw[W-1:0];

    // Reduction happens in stage 0; later stages only delay the result.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld <= '0;
            for (int k = 0; k < N; k++) dat[k] <= '0;
        end else begin
            vld[0] <= en;
            dat[0] <= red;
            for (int k = 1; k < N; k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
            end
        end
    end

    assign c           = dat[N-1];
    assign ready_pulse = vld[N-1];

endmodule

// File: rtl/field_accumulator.sv
// Accumulates a run of field elements through one shared field_adder.
// Result is held with a valid/ready handshake until consumed.
module field_accumulator
    import field_accumulator_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [`F_NBITS-1:0] in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [`F_NBITS-1:0] sum,
    output logic [CNT_W-1:0]    n_terms,
    output logic                busy
);

    localparam int W = `F_NBITS;

    state_e         state;
    state_e         state_nxt;
    logic [W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]   sum_q;
    logic [CNT_W-1:0] n_q;
    logic           last_q;
    logic           adder_en;
    logic [W-1:0]   add_c;
    logic           add_rdy;

    field_adder u_adder (
        .clk         (clk),
        .rstb        (~rst),
        .en          (adder_en),
        .a           (acc),
        .b           (in_data),
        .c           (add_c),
        .ready_pulse (add_rdy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        adder_en  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_last ? DONE : WAIT_IN;
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    adder_en  = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                if (add_rdy) state_nxt = last_q ? DONE : WAIT_IN;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers change only on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            sum_q  <= '0;
            n_q    <= '0;
            last_q <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        acc <= in_data;
                        cnt <= CNT_W'(1);
                        if (in_last) begin
                            sum_q <= in_data;
                            n_q   <= CNT_W'(1);
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        last_q <= in_last;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                ADD: begin
                    if (add_rdy) begin
                        acc <= add_c;
                        if (last_q) begin
                            sum_q <= add_c;
                            n_q   <= cnt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum     = sum_q;
    assign n_terms = n_q;

endmodule

// File: doc/field_accumulator.md
FIELD_ACCUMULATOR -- requirements
Module: field_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the term counter and the n_terms output.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a new accumulation; honoured only in IDLE.
REQ-005 SHALL have port in_valid, input, 1: in_data/in_last are valid this cycle.
REQ-006 SHALL have port in_data, input, `F_NBITS: field element to add, already reduced below the field prime p.
REQ-007 SHALL have port in_last, input, 1: the current term is the final term of the run.
REQ-008 SHALL have port in_ready, output, 1: the block accepts a term this cycle; a transfer occurs when in_valid && in_ready.
REQ-009 SHALL have port out_valid, output, 1: sum and n_terms are valid; held until out_ready.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port sum, output, `F_NBITS: field sum of all accepted terms, mod p.
REQ-012 SHALL have port n_terms, output, CNT_W: number of terms accepted in the run.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, WAIT_IN, ADD and DONE.
REQ-015 SHALL transition IDLE->LOAD on start; start outside IDLE SHALL be ignored.
REQ-016 SHALL assert in_ready only in LOAD and WAIT_IN, combinationally from state.
REQ-017 On a LOAD transfer, SHALL set acc<=in_data and cnt<=1 with no adder operation, then go to DONE if in_last, else to WAIT_IN.
REQ-018 On a WAIT_IN transfer, SHALL pulse adder en for exactly one cycle with a=acc and b=in_data, latch in_last, increment cnt, and go to ADD.
REQ-019 In ADD, SHALL set acc<=c on adder ready_pulse, then go to DONE if latched last, else to WAIT_IN; per-term latency is `F_ADD_CYCLES plus 1 cycle.
REQ-020 SHALL never issue a second en while in ADD; in_valid in ADD SHALL be held off via in_ready=0.
REQ-021 In DONE, SHALL assert out_valid with sum=acc and n_terms=cnt; on out_ready, SHALL go to IDLE with out_valid low the next cycle.
REQ-022 SHALL wrap cnt modulo 2^CNT_W silently on overflow; sum correctness SHALL be unaffected.
REQ-023 SHALL perform all addition mod p in the adder; the block SHALL hold no modular logic of its own.
REQ-024 SHALL update sum and n_terms only on entry to DONE; they SHALL hold their last value in IDLE.
REQ-025 SHALL take start asserted in the same cycle as a DONE handshake as IDLE-only, so that start is ignored in that cycle.

Reset
REQ-026 While rst is high, SHALL force state=IDLE and acc, cnt, sum, n_terms, out_valid, in_ready, busy and adder en all to 0.
REQ-027 SHALL also reset the adder instance by driving its active-low reset from ~rst.
REQ-028 On reset mid-run, SHALL abandon the run, discard any in-flight adder result, and SHALL NOT assert out_valid.

Structure
REQ-029 SHALL declare the state enum typedef in a shared package, field_accumulator_pkg.
REQ-030 SHALL take `F_NBITS and `F_ADD_CYCLES from the existing field arithmetic defines; these SHALL NOT be duplicated.
REQ-031 SHALL instantiate exactly one field_adder sub-module, with its clk tied to clk and its rstb to ~rst.

Verification
REQ-032 Bench SHALL cover: start, terms 3, 4, 5 (last on 5) -> out_valid with sum=12, n_terms=3.
REQ-033 Bench SHALL cover: start, single term 7 with in_last -> DONE with no adder en pulse, sum=7, n_terms=1.
REQ-034 Bench SHALL cover: terms p-1 and 2 -> sum=1 (modular wrap-around).
REQ-035 Bench SHALL cover: in_valid held high throughout a 4-term run -> in_ready low in every ADD cycle, exactly 3 en pulses, each separated by at least `F_ADD_CYCLES cycles.
REQ-036 Bench SHALL cover: out_ready held low for 5 cycles in DONE -> out_valid, sum and n_terms stable; start pulses in those cycles ignored.
REQ-037 Bench SHALL cover: rst asserted in ADD -> all outputs 0 at once; next run 1+1 -> sum=2, with no stale result.
